// File: rtl/ay8_pkg.sv
// Shared widths and bus-phase/direction types for the AY8 fetch path.
package ay8_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PC_RESET = 8'h00;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} bus_phase_t;
  typedef enum logic {RD, WR} rw_t;

endpackage

// File: rtl/ay8_bus_if.sv
// Multiplexed address/data uniBus plus sideband; the tri-state net is resolved
// here from each side's registered output enable.
interface ay8_bus_if;
  import ay8_pkg::*;

  logic              core_oe;
  logic [DATA_W-1:0] core_do;
  logic              mem_oe;
  logic [DATA_W-1:0] mem_do;
  logic              isRunning;
  rw_t               rw;
  bus_phase_t        phase;
  wire  [DATA_W-1:0] bus;

  // Enables are mutually exclusive by phase, so at most one side drives.
  assign bus = core_oe ? core_do : (mem_oe ? mem_do : 'z);

  modport master (output core_oe, core_do, isRunning, rw, phase, input bus);
  modport slave  (output mem_oe, mem_do, input rw, phase, bus);

endinterface

// File: rtl/ay8_core.sv
// AY8 core front end: PC/IR, request arbitration and the uniBus master FSM.
module ay8_core
  import ay8_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              fetch_req,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc,
  ay8_bus_if.master         bus_if
);

  bus_phase_t        state_q, state_d;
  rw_t               rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] pc_d;
  logic [DATA_W-1:0] ir_d;
  logic              ir_valid_d;
  logic              busy_d;
  logic              oe_d;
  logic [DATA_W-1:0] do_d;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q        <= IDLE;
      rw_q           <= RD;
      addr_q         <= '0;
      wdata_q        <= '0;
      pc             <= PC_RESET;
      ir             <= '0;
      ir_valid       <= 1'b0;
      busy           <= 1'b0;
      bus_if.core_oe <= 1'b0;
      bus_if.core_do <= '0;
    end else begin
      state_q        <= state_d;
      rw_q           <= rw_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      pc             <= pc_d;
      ir             <= ir_d;
      ir_valid       <= ir_valid_d;
      busy           <= busy_d;
      bus_if.core_oe <= oe_d;
      bus_if.core_do <= do_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    pc_d       = pc;
    ir_d       = ir;
    ir_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Fetch wins a tie; the simultaneous write is simply dropped.
        if (fetch_req) begin
          state_d = ADDR;
          rw_d    = RD;
          addr_d  = pc;
        end else if (wr_req) begin
          state_d = ADDR;
          rw_d    = WR;
          addr_d  = wr_addr;
          wdata_d = wr_data;
        end
      end
      ADDR: state_d = DATA;
      DATA: begin
        state_d = IDLE;
        if (rw_q == RD) begin
          ir_d       = bus_if.bus;
          pc_d       = pc + ADDR_W'(1);
          ir_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    oe_d   = (state_d == ADDR) || ((state_d == DATA) && (rw_d == WR));
    do_d   = (state_d == ADDR) ? DATA_W'(addr_d) : wdata_d;
  end

  assign bus_if.phase     = state_q;
  assign bus_if.rw        = rw_q;
  assign bus_if.isRunning = busy;

endmodule

// File: rtl/ay8_memory.sv
// 256x8 uniBus slave: latches address/direction in ADDR, drives or writes in DATA.
module ay8_memory
  import ay8_pkg::*;
(
  input  logic     CLK,
  input  logic     RST,
  ay8_bus_if.slave bus_if
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] addr_q;
  logic              wr_pend_q;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      addr_q        <= '0;
      wr_pend_q     <= 1'b0;
      bus_if.mem_oe <= 1'b0;
      bus_if.mem_do <= '0;
    end else begin
      wr_pend_q     <= 1'b0;
      bus_if.mem_oe <= 1'b0;
      if (bus_if.phase == ADDR) begin
        addr_q        <= ADDR_W'(bus_if.bus);
        wr_pend_q     <= (bus_if.rw == WR);
        bus_if.mem_oe <= (bus_if.rw == RD);
        bus_if.mem_do <= mem[ADDR_W'(bus_if.bus)];
      end
    end
  end

  // Array is never reset; a reset landing on the DATA edge cancels the write.
  always_ff @(posedge CLK) begin
    if (RST && wr_pend_q && (bus_if.phase == DATA)) begin
      mem[addr_q] <= bus_if.bus;
    end
  end

endmodule

// File: rtl/ay8_core_mem_system.sv
// AY8 fetch path: core and memory joined by the shared uniBus interface.
module ay8_core_mem_system
  import ay8_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              fetch_req,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] bus_mon
);

  ay8_bus_if bus_if ();

  ay8_core u_core (
    .CLK       (CLK),
    .RST       (RST),
    .fetch_req (fetch_req),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .ir        (ir),
    .ir_valid  (ir_valid),
    .pc        (pc),
    .bus_if    (bus_if.master)
  );

  ay8_memory u_mem (
    .CLK    (CLK),
    .RST    (RST),
    .bus_if (bus_if.slave)
  );

  assign bus_mon = bus_if.bus;

endmodule

// File: tb/tb_ay8_core_mem_system.sv
// Randomized bench for the AY8 fetch path against a transaction-level memory/PC model.
module tb_ay8_core_mem_system;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       fetch_req = 1'b0;
  logic       wr_req = 1'b0;
  logic [7:0] wr_addr = 8'h00;
  logic [7:0] wr_data = 8'h00;
  logic       busy, ir_valid;
  logic [7:0] ir, pc, bus_mon;

  int checks = 0;
  int failures = 0;

  logic [7:0] ref_mem [256];
  logic [7:0] ref_pc = 8'h00;
  logic [7:0] ref_ir = 8'h00;

  always #5 CLK = ~CLK;

  ay8_core_mem_system dut (
    .CLK       (CLK),
    .RST       (RST),
    .fetch_req (fetch_req),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .ir        (ir),
    .ir_valid  (ir_valid),
    .pc        (pc),
    .bus_mon   (bus_mon)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic quiet();
    fetch_req = 1'b0;
    wr_req    = 1'b0;
  endtask

  // Random requests while busy must have no effect.
  task automatic noise();
    fetch_req = 1'($urandom);
    wr_req    = 1'($urandom);
    wr_addr   = 8'($urandom);
    wr_data   = 8'($urandom);
  endtask

  task automatic do_reset();
    quiet();
    RST = 1'b0;
    tick();
    RST = 1'b1;
    ref_pc = 8'h00;
    ref_ir = 8'h00;
    check("rst_pc", 32'(pc), 32'(ref_pc));
    check("rst_ir", 32'(ir), 32'(ref_ir));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_irv", 32'(ir_valid), 32'd0);
  endtask

  // Fetch with a random, always-dropped, colliding write request.
  task automatic do_fetch();
    fetch_req = 1'b1;
    wr_req    = 1'($urandom);
    wr_addr   = 8'($urandom);
    wr_data   = 8'($urandom);
    tick();
    check("f_busy_addr", 32'(busy), 32'd1);
    check("f_bus_addr", 32'(bus_mon), 32'(ref_pc));
    noise();
    tick();
    check("f_busy_data", 32'(busy), 32'd1);
    check("f_bus_data", 32'(bus_mon), 32'(ref_mem[ref_pc]));
    noise();
    tick();
    quiet();
    ref_ir = ref_mem[ref_pc];
    ref_pc = ref_pc + 8'd1;
    check("f_busy_done", 32'(busy), 32'd0);
    check("f_irv", 32'(ir_valid), 32'd1);
    check("f_ir", 32'(ir), 32'(ref_ir));
    check("f_pc", 32'(pc), 32'(ref_pc));
    tick();
    check("f_irv_pulse", 32'(ir_valid), 32'd0);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    fetch_req = 1'b0;
    wr_req    = 1'b1;
    wr_addr   = a;
    wr_data   = d;
    tick();
    check("w_busy_addr", 32'(busy), 32'd1);
    check("w_bus_addr", 32'(bus_mon), 32'(a));
    noise();
    tick();
    check("w_bus_data", 32'(bus_mon), 32'(d));
    noise();
    tick();
    quiet();
    ref_mem[a] = d;
    check("w_busy_done", 32'(busy), 32'd0);
    check("w_irv", 32'(ir_valid), 32'd0);
    check("w_pc", 32'(pc), 32'(ref_pc));
    check("w_ir", 32'(ir), 32'(ref_ir));
    tick();
  endtask

  initial begin
    logic [7:0] start_pc;
    logic [7:0] victim;
    logic [7:0] old_val;
    int         r;

    RST = 1'b0;
    tick();
    tick();
    RST = 1'b1;
    check("init_pc", 32'(pc), 32'd0);
    check("init_busy", 32'(busy), 32'd0);
    check("init_irv", 32'(ir_valid), 32'd0);

    // Preload every location; 0..3 get the fixed program bytes.
    for (int a = 0; a < 256; a++) begin
      if (a < 4) do_write(8'(a), 8'(8'h10 + a));
      else       do_write(8'(a), 8'($urandom));
    end

    // Memory survives reset; first fetch after reset.
    do_reset();
    do_fetch();
    check("first_ir", 32'(ir), 32'h10);
    check("first_pc", 32'(pc), 32'd1);
    tick();
    check("gap_busy", 32'(busy), 32'd0);
    do_fetch();
    check("second_ir", 32'(ir), 32'h11);
    check("second_pc", 32'(pc), 32'd2);

    // Back-to-back fetches with fetch_req held high: one per 3 cycles.
    do_reset();
    start_pc = ref_pc;
    fetch_req = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      check("cont_busy", 32'(busy), (k % 3 != 2) ? 32'd1 : 32'd0);
      check("cont_irv", 32'(ir_valid), (k % 3 == 2) ? 32'd1 : 32'd0);
      if (k % 3 == 2) begin
        check("cont_ir", 32'(ir), 32'(ref_mem[8'(start_pc + 8'(k / 3))]));
        check("cont_pc", 32'(pc), 32'(8'(start_pc + 8'(k / 3 + 1))));
      end
    end
    quiet();
    ref_pc = start_pc + 8'd4;
    ref_ir = ref_mem[start_pc + 8'd3];
    check("cont_seq_last", 32'(ir), 32'h13);
    tick();

    // Simultaneous fetch and write: the write to the next PC is dropped.
    victim  = ref_pc + 8'd1;
    old_val = ref_mem[victim];
    fetch_req = 1'b1;
    wr_req    = 1'b1;
    wr_addr   = victim;
    wr_data   = ~old_val;
    tick();
    check("coll_bus_addr", 32'(bus_mon), 32'(ref_pc));
    quiet();
    tick();
    tick();
    ref_ir = ref_mem[ref_pc];
    ref_pc = ref_pc + 8'd1;
    check("coll_ir", 32'(ir), 32'(ref_ir));
    check("coll_pc", 32'(pc), 32'(ref_pc));
    tick();
    do_fetch();
    check("coll_reread", 32'(ir), 32'(old_val));

    // Reset during the DATA phase of a write aborts it.
    fetch_req = 1'b0;
    wr_req    = 1'b1;
    wr_addr   = 8'd2;
    wr_data   = 8'h55;
    tick();
    quiet();
    tick();
    RST = 1'b0;
    tick();
    RST = 1'b1;
    ref_pc = 8'h00;
    ref_ir = 8'h00;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_pc", 32'(pc), 32'd0);
    do_fetch();
    do_fetch();
    do_fetch();
    check("abort_mem", 32'(ir), 32'h12);

    // Full PC wrap through all 256 addresses.
    do_write(8'hFF, 8'hAA);
    do_reset();
    for (int i = 0; i < 256; i++) do_fetch();
    check("wrap_ir", 32'(ir), 32'hAA);
    check("wrap_pc", 32'(pc), 32'd0);

    // Random mix of fetches, writes and resets with idle gaps.
    for (int i = 0; i < 80; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 5)      do_fetch();
      else if (r < 9) do_write(8'($urandom), 8'($urandom));
      else            do_reset();
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        tick();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_irv", 32'(ir_valid), 32'd0);
        check("idle_pc", 32'(pc), 32'(ref_pc));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
